// File: rtl/present_decrypt_core.sv
// Iterative PRESENT block decryption: whitening on accept, one inverse round per cycle,
// round keys fetched from an external key store through rk_idx.
module present_decrypt_core #(
  parameter int unsigned NROUNDS = 31,
  parameter int unsigned KIW     = $clog2(NROUNDS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [63:0]    in_data,
  output logic [KIW-1:0] rk_idx,
  input  logic [63:0]    rk,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [63:0]    out_data
);

  localparam int unsigned W = 64;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state_q, state_n;
  logic [KIW-1:0] cnt_q, cnt_n;
  logic [W-1:0]   data_n;
  logic           in_ready_n, out_valid_n;
  logic [KIW-1:0] rk_idx_n;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;
      4'h1: inv_sbox = 4'hE;
      4'h2: inv_sbox = 4'hF;
      4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;
      4'h5: inv_sbox = 4'h1;
      4'h6: inv_sbox = 4'h2;
      4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;
      4'h9: inv_sbox = 4'h4;
      4'hA: inv_sbox = 4'h6;
      4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;
      4'hD: inv_sbox = 4'h7;
      4'hE: inv_sbox = 4'h9;
      default: inv_sbox = 4'hA;
    endcase
  endfunction

  // invP is pure wiring; bit 63 stays in place
  function automatic logic [W-1:0] inv_round(input logic [W-1:0] s, input logic [W-1:0] k);
    logic [W-1:0] p;
    logic [W-1:0] r;
    for (int i = 0; i < 63; i++) begin
      p[i] = s[6'((16 * i) % 63)];
    end
    p[63] = s[63];
    for (int j = 0; j < 16; j++) begin
      r[4*j +: 4] = inv_sbox(p[4*j +: 4]);
    end
    return r ^ k;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rk_idx    <= KIW'(NROUNDS);
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      out_data  <= data_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      rk_idx    <= rk_idx_n;
    end
  end

  // in_ready is a registered decode, so it rises one cycle after re-entering IDLE
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    data_n      = out_data;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    rk_idx_n    = rk_idx;
    case (state_q)
      IDLE: begin
        in_ready_n = 1'b1;
        rk_idx_n   = KIW'(NROUNDS);
        if (in_valid && in_ready) begin
          data_n     = in_data ^ rk;
          cnt_n      = KIW'(NROUNDS - 1);
          rk_idx_n   = KIW'(NROUNDS - 1);
          in_ready_n = 1'b0;
          state_n    = ROUND;
        end
      end
      ROUND: begin
        data_n = inv_round(out_data, rk);
        if (cnt_q == '0) begin
          out_valid_n = 1'b1;
          rk_idx_n    = KIW'(NROUNDS);
          state_n     = DONE;
        end else begin
          cnt_n    = cnt_q - KIW'(1);
          rk_idx_n = cnt_q - KIW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_present_decrypt_core.sv
// Scoreboard bench for present_decrypt_core: forward PRESENT-80 model produces ciphertexts,
// expected plaintexts are queued on acceptance and compared at the output handshake.
module tb_present_decrypt_core;

  localparam int unsigned KIW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [63:0]    in_data;
  logic [KIW-1:0] rk_idx;
  logic [63:0]    rk;
  logic           out_valid;
  logic           out_ready;
  logic [63:0]    out_data;

  logic [63:0] ks [32];
  logic [63:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int last_acc = 0;
  bit last_acc_ok = 1'b0;
  bit b2b = 1'b0;
  bit ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk = ks[rk_idx];

  present_decrypt_core #(.NROUNDS(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[4*x +: 4];
  endfunction

  // PRESENT-80 key schedule: ks[i] holds round key K(i+1)
  task automatic set_key(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 0; i < 32; i++) begin
      ks[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i + 1);
    end
  endtask

  function automatic logic [63:0] enc(input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    s = pt;
    for (int r = 0; r < 31; r++) begin
      s = s ^ ks[r];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox(s[4*j +: 4]);
      for (int i = 0; i < 63; i++) t[(16 * i) % 63] = s[i];
      t[63] = s[63];
      s = t;
    end
    return s ^ ks[31];
  endfunction

  // acceptance timing, latency and output scoreboard
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      if (b2b && last_acc_ok) check_eq("b2b_spacing", 64'(cyc - last_acc), 64'd34);
      last_acc    = cyc;
      last_acc_ok = 1'b1;
      acc_cyc     = cyc;
    end
    if (out_valid && !ov_prev) check_eq("latency", 64'(cyc - acc_cyc), 64'd32);
    ov_prev = out_valid;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_output", 64'(out_valid), 64'd0);
      else check_eq("plaintext", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] ct, input logic [63:0] exp, input bit hold);
    int n;
    n = 0;
    in_data  = ct;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_timeout", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] pt;
    logic [63:0] held;
    logic [63:0] b_pt [4];
    logic [63:0] b_ct [4];
    int seen;
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    set_key(80'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_rk_idx", 64'(rk_idx), 64'd31);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // known answer, key 0, with round-key index trace
    check_eq("rk_idx_t0", 64'(rk_idx), 64'd31);
    send(64'h5579C1387B228445, 64'h0, 1'b0);
    for (int k = 30; k >= 0; k--) begin
      check_eq("rk_idx_seq", 64'(rk_idx), 64'(k));
      @(posedge clk);
      #1;
    end
    wait_drain();

    // known answers, all-ones key
    set_key({80{1'b1}});
    send(64'h3333DCD3213210D2, {64{1'b1}}, 1'b0);
    wait_drain();
    send(64'hE72C46C0F5945049, 64'h0, 1'b0);
    wait_drain();

    // backpressure: output held for 10 cycles, input pulses ignored
    set_key({$urandom(), $urandom(), 16'($urandom())});
    pt = {$urandom(), $urandom()};
    out_ready = 1'b0;
    send(enc(pt), pt, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("bp_valid_timeout", 64'(out_valid), 64'd1);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      in_data  = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_out_data", out_data, held);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check_eq("bp_idle_ready", 64'(in_ready), 64'd1);
    check_eq("bp_scoreboard", 64'(exp_q.size()), 64'd0);

    // reset mid-operation
    pt = {$urandom(), $urandom()};
    send(enc(pt), pt, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_out_data", out_data, 64'd0);
    check_eq("mid_rst_rk_idx", 64'(rk_idx), 64'd31);
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_eq("mid_rst_no_output", 64'(seen), 64'd0);
    send(enc(pt), pt, 1'b0);
    wait_drain();

    // back-to-back with in_valid and out_ready held high
    set_key({$urandom(), $urandom(), 16'($urandom())});
    for (int i = 0; i < 4; i++) begin
      b_pt[i] = {$urandom(), $urandom()};
      b_ct[i] = enc(b_pt[i]);
    end
    b2b = 1'b1;
    last_acc_ok = 1'b0;
    for (int i = 0; i < 4; i++) send(b_ct[i], b_pt[i], i < 3);
    wait_drain();
    b2b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
